// File: rtl/ddr3_refresh_sched.sv
// rtl/ddr3_refresh_sched.sv - DDR3 refresh scheduler: tREFI tracking, owed-refresh postponement, bank drain, tRFC hold-off
// Optional feature macro: DDR3_REF_STATS_EN adds the ref_count output (REF commands issued).
`timescale 1ns/1ps
module ddr3_refresh_sched #(
    parameter int T_REFI    = 6240,
    parameter int T_RFC     = 88,
    parameter int URGENT_TH = 4,
    parameter int MAX_OWED  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        refresh_en,
    input  logic [3:0]  bank_idle,
    output logic        refresh_req,
    output logic        refresh_cmd_valid,
    output logic        refresh_busy,
    output logic [3:0]  owed_cnt,
    output logic        urgent,
    output logic        ref_violation
`ifdef DDR3_REF_STATS_EN
    ,
    output logic [15:0] ref_count
`endif
);

    localparam int REFI_W = $clog2(T_REFI);
    localparam int RFC_W  = $clog2(T_RFC);

    localparam logic [REFI_W-1:0] REFI_LAST = REFI_W'(T_REFI - 1);
    // WAIT_RFC spans T_RFC-1 cycles, so its counter ends at T_RFC-2.
    localparam logic [RFC_W-1:0]  RFC_LAST  = RFC_W'(T_RFC - 2);
    localparam logic [3:0]        OWED_MAX  = 4'(MAX_OWED);
    localparam logic [3:0]        URG_LVL   = 4'(URGENT_TH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        ISSUE    = 2'd2,
        WAIT_RFC = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [REFI_W-1:0] refi_cnt;
    logic [RFC_W-1:0]  rfc_cnt;
    logic              refi_wrap;
    logic              rfc_done;
    logic              all_idle;
    logic              start_ok;

    assign all_idle     = (bank_idle == 4'hF);
    assign refi_wrap    = refresh_en && (refi_cnt == REFI_LAST);
    assign rfc_done     = (rfc_cnt == RFC_LAST);
    assign urgent       = (owed_cnt >= URG_LVL);
    assign refresh_busy = (state != IDLE);
    assign start_ok     = refresh_en && (owed_cnt != 4'd0) && (urgent || all_idle);

    // tREFI interval counter: free-runs while enabled, holds while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refi_cnt <= '0;
        end else if (refresh_en) begin
            refi_cnt <= refi_wrap ? '0 : refi_cnt + REFI_W'(1);
        end
    end

    // Owed-refresh bookkeeping; a wrap and a REF in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owed_cnt      <= 4'd0;
            ref_violation <= 1'b0;
        end else begin
            case ({refi_wrap, refresh_cmd_valid})
                2'b10: begin
                    if (owed_cnt == OWED_MAX) begin
                        ref_violation <= 1'b1;
                    end else begin
                        owed_cnt <= owed_cnt + 4'd1;
                    end
                end
                2'b01:   owed_cnt <= owed_cnt - 4'd1;
                default: owed_cnt <= owed_cnt;
            endcase
        end
    end

    // tRFC hold-off counter, only advancing inside WAIT_RFC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rfc_cnt <= '0;
        end else if (state == WAIT_RFC && !rfc_done) begin
            rfc_cnt <= rfc_cnt + RFC_W'(1);
        end else begin
            rfc_cnt <= '0;
        end
    end

    // State register plus registered versions of the bank/cmd_gen strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            refresh_req       <= 1'b0;
            refresh_cmd_valid <= 1'b0;
        end else begin
            state             <= next_state;
            refresh_req       <= (next_state != IDLE);
            refresh_cmd_valid <= (next_state == ISSUE);
        end
    end

    // Next-state decode. At the end of tRFC a further owed refresh re-enters
    // DRAIN directly so back-to-back REFs are spaced T_RFC+1 cycles apart.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start_ok) next_state = DRAIN;
            DRAIN:    if (all_idle) next_state = ISSUE;
            ISSUE:    next_state = WAIT_RFC;
            WAIT_RFC: if (rfc_done) next_state = start_ok ? DRAIN : IDLE;
            default:  next_state = IDLE;
        endcase
    end

`ifdef DDR3_REF_STATS_EN
    // REF statistics counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_count <= 16'd0;
        end else if (refresh_cmd_valid) begin
            ref_count <= ref_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr3_refresh_sched.sv
// tb/tb_ddr3_refresh_sched.sv - self-checking bench for ddr3_refresh_sched with REF-timing scoreboard
`timescale 1ns/1ps
module tb_ddr3_refresh_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        refresh_en;
    logic [3:0]  bank_idle;
    logic        refresh_req;
    logic        refresh_cmd_valid;
    logic        refresh_busy;
    logic [3:0]  owed_cnt;
    logic        urgent;
    logic        ref_violation;
`ifdef DDR3_REF_STATS_EN
    logic [15:0] ref_count;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_q[$];
    logic [3:0] prev_idle = 4'h0;
    logic       seen;

    ddr3_refresh_sched #(
        .T_REFI(100), .T_RFC(10), .URGENT_TH(4), .MAX_OWED(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .refresh_en(refresh_en),
        .bank_idle(bank_idle),
        .refresh_req(refresh_req),
        .refresh_cmd_valid(refresh_cmd_valid),
        .refresh_busy(refresh_busy),
        .owed_cnt(owed_cnt),
        .urgent(urgent),
        .ref_violation(ref_violation)
`ifdef DDR3_REF_STATS_EN
        ,
        .ref_count(ref_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset(input logic en, input logic [3:0] idle);
        @(negedge clk);
        rst_n      = 1'b0;
        refresh_en = en;
        bank_idle  = idle;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // Scoreboard consumer: every REF pulse must match the next expected cycle.
    always @(negedge clk) begin
        if (rst_n && refresh_cmd_valid) begin
            check("ref_prev_idle", 32'(prev_idle), 32'hF);
            if (exp_q.size() == 0) begin
                check("ref_unexpected", cyc, 0);
            end else begin
                check("ref_cycle", cyc, exp_q.pop_front());
            end
        end
        prev_idle = bank_idle;
    end

    initial begin
        rst_n      = 1'b0;
        refresh_en = 1'b0;
        bank_idle  = 4'h0;

        // Scenario 1: single refresh with banks idle
        do_reset(1'b1, 4'hF);
        check("rst_req", refresh_req, 0);
        check("rst_cmd", refresh_cmd_valid, 0);
        check("rst_busy", refresh_busy, 0);
        check("rst_owed", owed_cnt, 0);
        check("rst_urgent", urgent, 0);
        check("rst_viol", ref_violation, 0);
        exp_q.push_back(102);
        tick_to(99);  check("s1_owed_99", owed_cnt, 0);
        tick_to(100); check("s1_owed_100", owed_cnt, 1);
        check("s1_req_100", refresh_req, 0);
        tick_to(101); check("s1_req_101", refresh_req, 1);
        tick_to(102); check("s1_cmd_102", refresh_cmd_valid, 1);
        tick_to(103); check("s1_cmd_103", refresh_cmd_valid, 0);
        check("s1_owed_103", owed_cnt, 0);
        tick_to(111); check("s1_req_111", refresh_req, 1);
        tick_to(112); check("s1_req_112", refresh_req, 0);
        check("s1_busy_112", refresh_busy, 0);
        tick_to(120); check("s1_sb_empty", exp_q.size(), 0);

        // Scenario 2: banks busy -> urgent drain, then 4 back-to-back REFs
        do_reset(1'b1, 4'h0);
        tick_to(399); check("s2_owed_399", owed_cnt, 3);
        check("s2_urg_399", urgent, 0);
        tick_to(400); check("s2_owed_400", owed_cnt, 4);
        check("s2_urg_400", urgent, 1);
        check("s2_req_400", refresh_req, 0);
        tick_to(401); check("s2_req_401", refresh_req, 1);
        tick_to(450); check("s2_drain_hold", refresh_busy, 1);
        bank_idle = 4'hF;
        for (int k = 0; k < 4; k++) exp_q.push_back(451 + 11 * k);
        tick_to(490); check("s2_owed_490", owed_cnt, 0);
        check("s2_urg_490", urgent, 0);
        check("s2_req_490", refresh_req, 1);
        tick_to(494); check("s2_req_494", refresh_req, 0);
        check("s2_sb_empty", exp_q.size(), 0);
`ifdef DDR3_REF_STATS_EN
        check("s2_ref_count", ref_count, 4);
`endif

        // Scenario 3: saturation and sticky violation
        do_reset(1'b1, 4'h0);
        tick_to(799); check("s3_owed_799", owed_cnt, 7);
        tick_to(800); check("s3_owed_800", owed_cnt, 8);
        tick_to(899); check("s3_viol_899", ref_violation, 0);
        tick_to(900); check("s3_viol_900", ref_violation, 1);
        check("s3_owed_900", owed_cnt, 8);
        tick_to(950);
        bank_idle = 4'hF;
        for (int k = 0; k < 9; k++) exp_q.push_back(951 + 11 * k);
        tick_to(1060); check("s3_owed_end", owed_cnt, 0);
        check("s3_viol_end", ref_violation, 1);
        check("s3_busy_end", refresh_busy, 0);
        check("s3_sb_empty", exp_q.size(), 0);

        // Scenario 4: tREFI wrap coincides with the REF pulse
        do_reset(1'b1, 4'h0);
        tick_to(100); check("s4_owed_100", owed_cnt, 1);
        tick_to(197);
        bank_idle = 4'hF;
        exp_q.push_back(199);
        exp_q.push_back(210);
        tick_to(198); check("s4_req_198", refresh_req, 1);
        tick_to(199); check("s4_owed_199", owed_cnt, 1);
        tick_to(200); check("s4_owed_200", owed_cnt, 1);
        tick_to(212); check("s4_owed_212", owed_cnt, 0);
        tick_to(215); check("s4_sb_empty", exp_q.size(), 0);

        // Scenario 5: reset asserted during WAIT_RFC
        do_reset(1'b1, 4'hF);
        exp_q.push_back(102);
        tick_to(105); check("s5_busy_105", refresh_busy, 1);
        rst_n = 1'b0;
        #1;
        check("s5_rst_req", refresh_req, 0);
        check("s5_rst_busy", refresh_busy, 0);
        check("s5_rst_owed", owed_cnt, 0);
        do_reset(1'b1, 4'hF);
        exp_q.push_back(102);
        tick_to(99);  check("s5_owed_99", owed_cnt, 0);
        tick_to(100); check("s5_owed_100", owed_cnt, 1);
        tick_to(110); check("s5_sb_empty", exp_q.size(), 0);

        // Scenario 6: refresh disabled at cycle 50
        do_reset(1'b1, 4'hF);
        tick_to(50);
        refresh_en = 1'b0;
        seen = 1'b0;
        while (cyc < 300) begin
            tick();
            if (refresh_req || refresh_busy) seen = 1'b1;
        end
        check("s6_no_req", seen, 0);
        check("s6_owed", owed_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
